led_array_pattern_driver: RTL

//   Parametrised LED array driver with autonomous pattern generation and PWM dimming.

---
 rtl/led_array_pattern_driver.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/led_array_pattern_driver.sv
// LED array driver: latches a pattern/mode/period on cfg_load, then animates
// the array on its own (static, blink, chase, fill) with PWM dimming applied
// to every lit channel. led_out is registered and polarity-adjusted.
module led_array_pattern_driver #(
  parameter int N_LED      = 8,
  parameter int PRESC_DIV  = 50000,
  parameter int PWM_W      = 4,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_load,
  input  logic [1:0]         cfg_mode,
  input  logic [N_LED-1:0]   cfg_pattern,
  input  logic [7:0]         cfg_period,
  input  logic [PWM_W-1:0]   brightness,
  output logic [N_LED-1:0]   led_out,
  output logic               step_pulse
);

  localparam int PW = (PRESC_DIV > 2) ? $clog2(PRESC_DIV) : 1;
  localparam int FW = $clog2(N_LED + 1);

  localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESC_DIV - 1);
  localparam logic [FW-1:0]    FILL_FULL  = FW'(N_LED);
  localparam logic [N_LED-1:0] ALL_OFF    = {N_LED{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  mode_e              mode_q,       mode_d;
  logic [N_LED-1:0]   pattern_q,    pattern_d;
  logic [7:0]         period_q,     period_d;
  logic [PW-1:0]      presc_q,      presc_d;
  logic [7:0]         step_cnt_q,   step_cnt_d;
  logic               phase_q,      phase_d;
  logic [FW-1:0]      fill_q,       fill_d;
  logic [PWM_W-1:0]   pwm_q,        pwm_d;
  logic [N_LED-1:0]   led_q,        led_d;
  logic               step_pulse_q, step_pulse_d;

  logic               tick;
  logic [7:0]         period_eff;
  logic               step_now;
  logic               lit;
  logic [N_LED-1:0]   fill_mask;
  logic [N_LED-1:0]   frame;

  // Base tick, step detection (a period of 0 behaves as 1) and PWM gate.
  assign tick       = (presc_q == PRESC_LAST);
  assign period_eff = (period_q == 8'd0) ? 8'd1 : period_q;
  assign step_now   = tick && (step_cnt_q == (period_eff - 8'd1));
  assign lit        = (pwm_q < brightness) || (&brightness);

  // Fill bar: channel gi is lit when it lies below the current fill level.
  for (genvar gi = 0; gi < N_LED; gi++) begin : g_fill
    assign fill_mask[gi] = (FW'(gi) < fill_q);
  end

  // Logical frame as a function of the animation state.
  always_comb begin
    frame = '0;
    unique case (mode_q)
      MODE_STATIC: frame = pattern_q;
      MODE_BLINK:  frame = phase_q ? '0 : pattern_q;
      MODE_CHASE:  frame = pattern_q;
      MODE_FILL:   frame = fill_mask;
      default:     frame = '0;
    endcase
  end

  // Next-state: a load restarts everything and suppresses a coincident step.
  always_comb begin
    mode_d       = mode_q;
    pattern_d    = pattern_q;
    period_d     = period_q;
    presc_d      = tick ? '0 : presc_q + PW'(1);
    step_cnt_d   = step_cnt_q;
    phase_d      = phase_q;
    fill_d       = fill_q;
    pwm_d        = pwm_q + PWM_W'(1);
    step_pulse_d = 1'b0;
    led_d        = (frame & {N_LED{lit}}) ^ ALL_OFF;

    if (cfg_load) begin
      mode_d     = mode_e'(cfg_mode);
      pattern_d  = cfg_pattern;
      period_d   = cfg_period;
      presc_d    = '0;
      step_cnt_d = 8'd0;
      phase_d    = 1'b0;
      fill_d     = '0;
      pwm_d      = '0;
    end else begin
      if (tick) begin
        step_cnt_d = step_now ? 8'd0 : step_cnt_q + 8'd1;
      end
      if (step_now) begin
        step_pulse_d = 1'b1;
        unique case (mode_q)
          MODE_BLINK: phase_d   = ~phase_q;
          MODE_CHASE: pattern_d = {pattern_q[N_LED-2:0], pattern_q[N_LED-1]};
          MODE_FILL:  fill_d    = (fill_q == FILL_FULL) ? '0 : fill_q + FW'(1);
          default:    ;
        endcase
      end
    end
  end

  // State and output registers with asynchronous return to the idle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q       <= MODE_STATIC;
      pattern_q    <= '0;
      period_q     <= 8'd1;
      presc_q      <= '0;
      step_cnt_q   <= 8'd0;
      phase_q      <= 1'b0;
      fill_q       <= '0;
      pwm_q        <= '0;
      led_q        <= ALL_OFF;
      step_pulse_q <= 1'b0;
    end else begin
      mode_q       <= mode_d;
      pattern_q    <= pattern_d;
      period_q     <= period_d;
      presc_q      <= presc_d;
      step_cnt_q   <= step_cnt_d;
      phase_q      <= phase_d;
      fill_q       <= fill_d;
      pwm_q        <= pwm_d;
      led_q        <= led_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign led_out    = led_q;
  assign step_pulse = step_pulse_q;

endmodule
